keystream_lfsr_gen: RTL

Parametrised Fibonacci LFSR keystream generator for the keyed XOR cipher datapath. It generalises the fixed 8-bit keystream LFSR in three ways: configurable register width and tap mask, multiple steps per output word, and a valid/ready output. It also discards a programmable number of warm-up steps after each key load and raises a rekey request after a programmable word count. It sits between key management and the XOR stage, which pulls one keystream word per data word.

---
 rtl/keystream_lfsr_gen_if.sv | 36 +++
 rtl/keystream_lfsr_gen.sv | 133 +++++++++++++
 2 files changed

// File: rtl/keystream_lfsr_gen_if.sv
// rtl/keystream_lfsr_gen_if.sv - keystream word stream between the LFSR generator and the XOR stage
//
// Purpose:
//   Carries one keystream word per transfer. A transfer happens on every
//   rising clock edge where out_valid and out_ready are both high.
//
// Signals:
//   out_data   [OUT_W-1:0]  keystream word, driven by the generator
//   out_valid               out_data holds a word that may be taken
//   out_ready               consumer takes the word this cycle
//
// Modports:
//   master  generator side (drives out_data/out_valid, samples out_ready)
//   slave   consumer side  (samples out_data/out_valid, drives out_ready)

interface keystream_lfsr_gen_if #(
  parameter int OUT_W = 8
);

  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/keystream_lfsr_gen.sv
// rtl/keystream_lfsr_gen.sv - parametrised Fibonacci LFSR keystream generator with warm-up and rekey request
//
// Purpose:
//   Produces keystream words for the keyed XOR cipher datapath. After a key
//   load the register is stepped WARMUP times with no output, then one word
//   (the low OUT_W bits of the state) is offered per cycle. Each accepted
//   word advances the register STEPS_PER_WORD steps in a single cycle.
//   A sticky rekey request is raised once REKEY_INTERVAL words have been
//   delivered since the last key load.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   load_key    one-cycle pulse: load key and restart warm-up (highest priority)
//   key         seed, sampled while load_key=1; zero is replaced by 1
//   stream      keystream word interface (master side)
//   rekey_req   sticky: word_count reached REKEY_INTERVAL
//   word_count  words transferred since the last key load, saturating
//   busy        high while discarding warm-up steps

module keystream_lfsr_gen #(
  parameter int               WIDTH          = 8,
  parameter logic [WIDTH-1:0] TAPS           = WIDTH'(8'hB8),
  parameter int               OUT_W          = 8,
  parameter int               STEPS_PER_WORD = 1,
  parameter int               WARMUP         = 4,
  parameter int               REKEY_INTERVAL = 0,
  parameter int               CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_key,
  input  logic [WIDTH-1:0]     key,
  keystream_lfsr_gen_if.master stream,
  output logic                 rekey_req,
  output logic [CNT_W-1:0]     word_count,
  output logic                 busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WARMUP = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  // Index of the final warm-up step; only meaningful when WARMUP > 0.
  localparam logic [7:0]       WARM_LAST = 8'((WARMUP > 0) ? (WARMUP - 1) : 0);
  localparam logic [CNT_W-1:0] REKEY_AT  = CNT_W'(REKEY_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [1:0]       ST_AFTER_LOAD = (WARMUP > 0) ? ST_WARMUP : ST_RUN;

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] state_step1;
  logic [WIDTH-1:0] state_stepn;
  logic [1:0]       fsm;
  logic [7:0]       warm_cnt;
  logic [CNT_W-1:0] count_inc;

  // One Fibonacci step: shift towards the MSB, parity of the tapped bits
  // enters at bit 0.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  // STEPS_PER_WORD steps chained combinationally so a whole word's worth of
  // advance fits in one cycle.
  function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] t;
    t = s;
    for (int i = 0; i < STEPS_PER_WORD; i++) begin
      t = lfsr_step(t);
    end
    return t;
  endfunction

  always_comb begin
    // The all-zero state is a fixed point of the LFSR; never let it in.
    seed        = (key == '0) ? WIDTH'(1) : key;
    state_step1 = lfsr_step(state);
    state_stepn = lfsr_advance(state);
    count_inc   = (word_count == CNT_MAX) ? word_count : (word_count + CNT_W'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= WIDTH'(1);
      fsm        <= ST_IDLE;
      warm_cnt   <= '0;
      word_count <= '0;
      rekey_req  <= 1'b0;
    end else if (load_key) begin
      // A transfer in the same cycle still completes on the consumer side
      // (it saw the old word) but is neither counted nor advances the state.
      state      <= seed;
      fsm        <= ST_AFTER_LOAD;
      warm_cnt   <= '0;
      word_count <= '0;
      rekey_req  <= 1'b0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          state <= state;
        end
        ST_WARMUP: begin
          state <= state_step1;
          if (warm_cnt == WARM_LAST) begin
            fsm      <= ST_RUN;
            warm_cnt <= '0;
          end else begin
            warm_cnt <= warm_cnt + 8'd1;
          end
        end
        ST_RUN: begin
          if (stream.out_ready) begin
            state      <= state_stepn;
            word_count <= count_inc;
            if ((REKEY_INTERVAL != 0) && (count_inc >= REKEY_AT)) begin
              rekey_req <= 1'b1;
            end
          end
        end
        default: begin
          fsm <= ST_IDLE;
        end
      endcase
    end
  end

  // Word comes straight from the register: no path from out_ready to out_data.
  assign stream.out_data  = state[OUT_W-1:0];
  assign stream.out_valid = (fsm == ST_RUN);
  assign busy             = (fsm == ST_WARMUP);

endmodule
